// File: rtl/sm_run_ctrl.sv
//------------------------------------------------------------------------------
// Module      : sm_run_ctrl
// Description : Run/step/breakpoint controller driving the schoolMIPS CPU clock
//               enable. Breakpoint logic is built only when the macro
//               SM_RUN_CTRL_BREAK_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm_run_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [1:0]  cmdOp,
    input  logic [31:0] cmdArg,
    input  logic [31:0] pc,
    output logic        cpuEn,
    output logic        halted,
    output logic [1:0]  stopCause,
    output logic [31:0] cycleCnt
);

    localparam logic [1:0] c_OP_HALT   = 2'b00;
    localparam logic [1:0] c_OP_RUN    = 2'b01;
    localparam logic [1:0] c_OP_STEP   = 2'b10;
    localparam logic [1:0] c_OP_SET_BP = 2'b11;

    localparam logic [1:0] c_CAUSE_RESET = 2'b00;
    localparam logic [1:0] c_CAUSE_HOST  = 2'b01;
    localparam logic [1:0] c_CAUSE_DONE  = 2'b10;
    localparam logic [1:0] c_CAUSE_BP    = 2'b11;

    localparam logic [CNT_W-1:0] c_REMAIN_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [1:0]       r_stopCause;
    logic [1:0]       w_stopCauseNext;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] w_remainNext;
    logic [CNT_W-1:0] w_stepLoad;
    logic [31:0]      r_cycleCnt;
    logic             w_bpHit;
    logic             w_cpuEn;
    logic             w_cmdReady;
    logic             w_accept;
    logic             w_resume;

    // While stepping only HALT may be taken, so a step can be aborted but not retargeted.
    assign w_cmdReady = (r_state == ST_HALTED) || (r_state == ST_RUN) ||
                        ((r_state == ST_STEP) && (cmdOp == c_OP_HALT));
    assign w_accept   = cmdValid && w_cmdReady;
    assign w_resume   = w_accept && (r_state == ST_HALTED) &&
                        ((cmdOp == c_OP_RUN) || (cmdOp == c_OP_STEP));
    assign w_cpuEn    = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_bpHit;
    assign w_stepLoad = (cmdArg[CNT_W-1:0] == '0) ? c_REMAIN_ONE : cmdArg[CNT_W-1:0];

`ifdef SM_RUN_CTRL_BREAK_EN
    logic [31:0] r_bpAddr;
    logic        r_bpValid;
    logic        r_skipBp;

    assign w_bpHit = r_bpValid && (pc == r_bpAddr) && !r_skipBp && (r_state != ST_HALTED);

    // An all-ones address is reserved as the "clear breakpoint" token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bpAddr  <= 32'h0;
            r_bpValid <= 1'b0;
        end else if (w_accept && (cmdOp == c_OP_SET_BP)) begin
            if (cmdArg == 32'hFFFF_FFFF) begin
                r_bpValid <= 1'b0;
            end else begin
                r_bpAddr  <= cmdArg;
                r_bpValid <= 1'b1;
            end
        end
    end

    // Resuming from a breakpoint stop lets the breakpointed instruction execute once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skipBp <= 1'b0;
        end else if (w_cpuEn) begin
            r_skipBp <= 1'b0;
        end else if (w_resume && (r_stopCause == c_CAUSE_BP)) begin
            r_skipBp <= 1'b1;
        end
    end
`else
    logic w_unusedBpInputs;

    assign w_bpHit          = 1'b0;
    assign w_unusedBpInputs = ^{cmdArg, pc};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HALTED;
            r_stopCause <= c_CAUSE_RESET;
            r_remain    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_stopCause <= w_stopCauseNext;
            r_remain    <= w_remainNext;
        end
    end

    // Stop-cause priority: breakpoint, then step exhaustion, then host halt.
    always_comb begin
        w_stateNext     = r_state;
        w_stopCauseNext = r_stopCause;
        w_remainNext    = r_remain;
        case (r_state)
            ST_HALTED: begin
                if (w_accept && (cmdOp == c_OP_RUN)) begin
                    w_stateNext = ST_RUN;
                end else if (w_accept && (cmdOp == c_OP_STEP)) begin
                    w_stateNext  = ST_STEP;
                    w_remainNext = w_stepLoad;
                end
            end
            ST_RUN: begin
                if (w_bpHit) begin
                    w_stateNext     = ST_HALTED;
                    w_stopCauseNext = c_CAUSE_BP;
                end else if (w_accept && (cmdOp == c_OP_HALT)) begin
                    w_stateNext     = ST_HALTED;
                    w_stopCauseNext = c_CAUSE_HOST;
                end
            end
            ST_STEP: begin
                if (w_bpHit) begin
                    w_stateNext     = ST_HALTED;
                    w_stopCauseNext = c_CAUSE_BP;
                end else if (w_cpuEn && (r_remain == c_REMAIN_ONE)) begin
                    w_stateNext     = ST_HALTED;
                    w_stopCauseNext = c_CAUSE_DONE;
                end else if (w_accept && (cmdOp == c_OP_HALT)) begin
                    w_stateNext     = ST_HALTED;
                    w_stopCauseNext = c_CAUSE_HOST;
                end else if (w_cpuEn) begin
                    w_remainNext = r_remain - c_REMAIN_ONE;
                end
            end
            default: begin
                w_stateNext = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycleCnt <= 32'h0;
        end else if (w_cpuEn) begin
            r_cycleCnt <= r_cycleCnt + 32'd1;
        end
    end

    assign cmdReady  = w_cmdReady;
    assign cpuEn     = w_cpuEn;
    assign halted    = (r_state == ST_HALTED);
    assign stopCause = r_stopCause;
    assign cycleCnt  = r_cycleCnt;

endmodule

`default_nettype wire

// File: tb/tb_sm_run_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_sm_run_ctrl
// Description : Directed self-checking bench for sm_run_ctrl with a simple PC
//               model that advances on every enabled cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm_run_ctrl;

    localparam logic [1:0] c_OP_HALT   = 2'b00;
    localparam logic [1:0] c_OP_RUN    = 2'b01;
    localparam logic [1:0] c_OP_STEP   = 2'b10;
    localparam logic [1:0] c_OP_SET_BP = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [31:0] cmdArg;
    logic [31:0] pc;
    logic        cpuEn;
    logic        halted;
    logic [1:0]  stopCause;
    logic [31:0] cycleCnt;

    int          nCmp = 0;
    int          nErr = 0;
    int          totalPulses = 0;
    int          mark;
    int          drops;

    sm_run_ctrl #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdOp     (cmdOp),
        .cmdArg    (cmdArg),
        .pc        (pc),
        .cpuEn     (cpuEn),
        .halted    (halted),
        .stopCause (stopCause),
        .cycleCnt  (cycleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU stand-in: PC advances one word per enabled cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'h0;
        else if (cpuEn) pc <= pc + 32'd1;
    end

    always @(posedge clk) begin
        if (cpuEn) totalPulses <= totalPulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdArg   = arg;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic waitHalted(input string tag, input int bound);
        for (int i = 0; i < bound && !halted; i++) tick();
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = c_OP_HALT;
        cmdArg   = 32'h0;
        repeat (3) tick();
        check("rst_cpuEn", 32'(cpuEn), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_cause", 32'(stopCause), 32'd0);
        check("rst_cycleCnt", cycleCnt, 32'd0);
        check("rst_cmdReady", 32'(cmdReady), 32'd1);
        rst_n = 1'b1;
        tick();

        // Free run for 20 enabled cycles, HALT presented in the 20th.
        cmd(c_OP_RUN, 32'h0);
        check("run_cpuEn", 32'(cpuEn), 32'd1);
        repeat (19) tick();
        check("run_cnt19", cycleCnt, 32'd19);
        cmd(c_OP_HALT, 32'h0);
        check("halt_cycleCnt", cycleCnt, 32'd20);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_cause", 32'(stopCause), 32'd1);
        check("halt_cpuEn", 32'(cpuEn), 32'd0);
        repeat (3) tick();
        check("halt_frozen", cycleCnt, 32'd20);

        // STEP 5
        mark = totalPulses;
        cmd(c_OP_STEP, 32'd5);
        check("step5_cpuEn", 32'(cpuEn), 32'd1);
        waitHalted("step5_halt", 20);
        check("step5_pulses", 32'(totalPulses - mark), 32'd5);
        check("step5_cause", 32'(stopCause), 32'd2);
        check("step5_cnt", cycleCnt, 32'd25);

        // STEP 0 behaves as STEP 1
        mark = totalPulses;
        cmd(c_OP_STEP, 32'd0);
        waitHalted("step0_halt", 10);
        check("step0_pulses", 32'(totalPulses - mark), 32'd1);
        check("step0_cause", 32'(stopCause), 32'd2);

        // STEP 100 aborted by HALT in the 10th enabled cycle
        mark = totalPulses;
        cmd(c_OP_STEP, 32'd100);
        cmdValid = 1'b1;
        cmdOp    = c_OP_RUN;
        #1;
        check("step_runReady", 32'(cmdReady), 32'd0);
        tick();
        cmdValid = 1'b0;
        repeat (8) tick();
        check("step_notHalted", 32'(halted), 32'd0);
        cmdValid = 1'b1;
        cmdOp    = c_OP_HALT;
        #1;
        check("step_haltReady", 32'(cmdReady), 32'd1);
        tick();
        cmdValid = 1'b0;
        check("abort_halted", 32'(halted), 32'd1);
        check("abort_cause", 32'(stopCause), 32'd1);
        check("abort_pulses", 32'(totalPulses - mark), 32'd10);
        check("abort_cnt", cycleCnt, 32'd36);

        // HALT coinciding with the terminal step: steps-done wins
        mark = totalPulses;
        cmd(c_OP_STEP, 32'd3);
        repeat (2) tick();
        cmd(c_OP_HALT, 32'h0);
        check("term_halted", 32'(halted), 32'd1);
        check("term_cause", 32'(stopCause), 32'd2);
        check("term_pulses", 32'(totalPulses - mark), 32'd3);

        // Asynchronous reset mid-run
        cmd(c_OP_RUN, 32'h0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cpuEn", 32'(cpuEn), 32'd0);
        check("arst_halted", 32'(halted), 32'd1);
        check("arst_cause", 32'(stopCause), 32'd0);
        check("arst_cnt", cycleCnt, 32'd0);
        check("arst_cmdReady", 32'(cmdReady), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SM_RUN_CTRL_BREAK_EN
        // Breakpoint at 6
        cmd(c_OP_SET_BP, 32'd6);
        cmd(c_OP_RUN, 32'h0);
        for (int i = 0; i < 20 && cpuEn; i++) tick();
        check("bp_cpuEnDrop", 32'(cpuEn), 32'd0);
        check("bp_pc", pc, 32'd6);
        check("bp_notYetHalted", 32'(halted), 32'd0);
        tick();
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_cause", 32'(stopCause), 32'd3);
        check("bp_pcHeld", pc, 32'd6);
        cmd(c_OP_RUN, 32'h0);
        check("bp_skipEn", 32'(cpuEn), 32'd1);
        tick();
        check("bp_pastPc", pc, 32'd7);
        check("bp_noRehit", 32'(halted), 32'd0);
        repeat (3) tick();
        cmd(c_OP_HALT, 32'h0);
        check("bp_haltPc", pc, 32'd11);

        // Clearing the breakpoint
        cmd(c_OP_SET_BP, 32'd14);
        cmd(c_OP_SET_BP, 32'hFFFF_FFFF);
        cmd(c_OP_RUN, 32'h0);
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            if (!cpuEn) drops++;
            tick();
        end
        check("clr_drops", 32'(drops), 32'd0);
        check("clr_pc", pc, 32'd17);
        check("clr_halted", 32'(halted), 32'd0);
        cmd(c_OP_HALT, 32'h0);

        // Breakpoint on the final step: step not executed, cause 11
        cmd(c_OP_SET_BP, 32'd21);
        mark = totalPulses;
        cmd(c_OP_STEP, 32'd4);
        waitHalted("bpstep_halt", 20);
        check("bpstep_cause", 32'(stopCause), 32'd3);
        check("bpstep_pulses", 32'(totalPulses - mark), 32'd3);
        check("bpstep_pc", pc, 32'd21);
`else
        // Without breakpoint logic SET_BP is accepted and ignored
        cmdValid = 1'b1;
        cmdOp    = c_OP_SET_BP;
        cmdArg   = 32'd6;
        #1;
        check("nobp_setReady", 32'(cmdReady), 32'd1);
        tick();
        cmdValid = 1'b0;
        cmd(c_OP_RUN, 32'h0);
        drops = 0;
        for (int i = 0; i < 12; i++) begin
            if (!cpuEn) drops++;
            tick();
        end
        check("nobp_drops", 32'(drops), 32'd0);
        check("nobp_pc", pc, 32'd12);
        check("nobp_halted", 32'(halted), 32'd0);
        cmd(c_OP_HALT, 32'h0);
        check("nobp_cause", 32'(stopCause), 32'd1);
        check("nobp_pcHalt", pc, 32'd13);
        mark = totalPulses;
        cmd(c_OP_STEP, 32'd4);
        waitHalted("nobp_stepHalt", 20);
        check("nobp_stepPulses", 32'(totalPulses - mark), 32'd4);
        check("nobp_stepCause", 32'(stopCause), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

`default_nettype wire
